// File: rtl/icb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icb_pkg
//  Description : Shared ICB widths and the response record carried through
//                the slave's response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ICB_MW = 4;

    typedef struct packed {
        logic [ICB_DW-1:0] rdata;
        logic              err;
    } icb_rsp_t;

endpackage : icb_pkg
`default_nettype wire

// File: rtl/icb_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : icb_rsp_fifo
//  Description : Small synchronous FIFO of ICB responses. Pointers wrap
//                modulo DEPTH (power of two); count is one bit wider so that
//                full and empty are distinguishable.
//  Revision    : 1.0 - initial release
// ============================================================================
module icb_rsp_fifo
    import icb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  icb_rsp_t                 i_data,
    input  logic                     i_pop,
    output icb_rsp_t                 o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_FULL = (c_PW+1)'(DEPTH);

    icb_rsp_t          r_mem [DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_PW:0]     r_count;

    logic              w_push;
    logic              w_pop;

    // Guard against overflow/underflow so a careless caller cannot corrupt the queue.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // Storage is write-only on push; not reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : icb_rsp_fifo
`default_nettype wire

// File: rtl/icb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : icb_sram_slave
//  Description : ICB slave backed by a word-organised register array with
//                byte-masked writes, address decode with error responses, a
//                saturating error counter and an in-order response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module icb_sram_slave
    import icb_pkg::*;
#(
    parameter logic [ICB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int                DEPTH     = 256,
    parameter int                RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ICB_AW-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [ICB_DW-1:0] icb_cmd_wdata,
    input  logic [ICB_MW-1:0] icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [ICB_DW-1:0] icb_rsp_rdata,
    output logic              icb_rsp_err,
    output logic [7:0]        err_count
);

    localparam int                      c_IDXW      = $clog2(DEPTH);
    localparam int                      c_CW        = $clog2(RSP_DEPTH) + 1;
    localparam logic [ICB_AW-3:0]       c_BASE_WORD = BASE_ADDR[ICB_AW-1:2];
    localparam logic [ICB_AW-3:0]       c_DEPTH_W   = (ICB_AW-2)'(DEPTH);
    localparam logic [c_CW-1:0]         c_RSP_FULL  = c_CW'(RSP_DEPTH);

    logic [ICB_DW-1:0] r_mem [DEPTH];
    logic [7:0]        r_err_count;

    logic [ICB_AW-3:0] w_word;
    logic [c_IDXW-1:0] w_index;
    logic              w_hit;
    logic              w_accept;
    logic              w_full;
    logic              w_empty;
    logic [c_CW-1:0]   w_count;
    logic              w_pop;
    icb_rsp_t          w_push_rsp;
    icb_rsp_t          w_head;

    // Word offset from the base; an address below the base wraps to a large
    // value, but the explicit lower-bound compare rejects it regardless.
    assign w_word   = icb_cmd_addr[ICB_AW-1:2] - c_BASE_WORD;
    assign w_index  = w_word[c_IDXW-1:0];
    assign w_hit    = (icb_cmd_addr[1:0] == 2'b00) &&
                      (icb_cmd_addr >= BASE_ADDR) &&
                      (w_word < c_DEPTH_W);

    // Ready is derived only from registered occupancy: no path from icb_rsp_ready.
    assign icb_cmd_ready = (w_count != c_RSP_FULL);
    assign w_accept      = icb_cmd_valid & ~w_full;
    assign w_pop         = icb_rsp_valid & icb_rsp_ready;

    // Build the response for the command being accepted this cycle.
    always_comb begin
        w_push_rsp.rdata = '0;
        w_push_rsp.err   = ~w_hit;
        if (w_hit && icb_cmd_read) begin
            w_push_rsp.rdata = r_mem[w_index];
        end
    end

    // Byte-lane write into the array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_hit && !icb_cmd_read) begin
            for (int b = 0; b < ICB_MW; b++) begin
                if (icb_cmd_wmask[b]) begin
                    r_mem[w_index][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    // Saturating count of decode-error responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_accept && !w_hit && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;

    icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (w_push_rsp),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Present the queue head; zero the data fields when nothing is queued.
    assign icb_rsp_valid = ~w_empty;
    assign icb_rsp_rdata = w_empty ? '0   : w_head.rdata;
    assign icb_rsp_err   = w_empty ? 1'b0 : w_head.err;

endmodule : icb_sram_slave
`default_nettype wire

// File: doc/icb_sram_slave.md
# icb_sram_slave

Synthesizable ICB slave that terminates the command/response channels driven by the team's ICB master: a word-organized register-array memory with byte-masked writes, address decode with error responses, and a small response queue that lets the master keep one command per cycle in flight while tolerating response back-pressure. It is the first real target behind the master in the ICB testbench and the template for later ICB peripherals.

## Interface
- BASE_ADDR, 32'h1000_0000: byte address of word 0; must be 4-byte aligned.
- DEPTH, 256: number of 32-bit words; power of two, ≥ 2.
- RSP_DEPTH, 2: response queue entries; power of two, ≥ 2.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- icb_cmd_valid  in  1  master presents a command.
- icb_cmd_ready  out  1  slave accepts the command this cycle.
- icb_cmd_addr  in  32  byte address.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte enables; bit i covers wdata[8i+7:8i].
- icb_rsp_valid  out  1  response available.
- icb_rsp_ready  in  1  master accepts the response.
- icb_rsp_rdata  out  32  read data; 0 for writes and errors.
- icb_rsp_err  out  1  1 = decode error.
- err_count  out  8  saturating count of error responses issued.

## Operation
- Accept = icb_cmd_valid & icb_cmd_ready. Each accepted command produces exactly one response, in order.
- Decode: hit when addr[1:0]==0 and BASE_ADDR ≤ addr < BASE_ADDR+4*DEPTH; index = (addr-BASE_ADDR)>>2, log2(DEPTH) bits.
- Write hit: on the accepting edge, update only the bytes with wmask bit set; response {rdata=0, err=0}. wmask=0 is a legal no-op write.
- Read hit: the array is read combinationally at accept; the response captures the pre-edge contents {rdata=mem[index], err=0}.
- Miss (misaligned or out of range), read or write: memory untouched; response {rdata=0, err=1}; err_count increments, saturating at 8'hFF.
- The response is pushed into the queue on the accepting edge. Head of queue drives icb_rsp_*; pop on icb_rsp_valid & icb_rsp_ready.
- icb_cmd_ready = (queue count != RSP_DEPTH). It depends only on registered state, with no combinational path from icb_rsp_ready.
- Simultaneous push and pop: count unchanged; both take effect.
- Memory array is not reset. Contents are undefined until written.

## Timing
- Reset values: icb_cmd_ready=1, icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, err_count=0. The queue is emptied.
- Latency: command accepted at edge N → icb_rsp_valid=1 in the cycle after edge N.
- Throughput: with icb_rsp_ready held high, one command per cycle indefinitely; count stays ≤ 1.
- Back-pressure: with icb_rsp_ready low, exactly RSP_DEPTH commands are accepted, then icb_cmd_ready=0. ready returns the cycle after the first pop.
- Read-after-write to the same word in consecutive accepts returns the new data.
- icb_rsp_rdata and icb_rsp_err hold stable while icb_rsp_valid=1 and icb_rsp_ready=0.
- Reset asserted mid-transaction: queued responses are discarded; the first cycle after the reset edge shows icb_rsp_valid=0. Writes already accepted remain in memory.

## Structure
- Package icb_pkg: ICB_AW=32, ICB_DW=32, ICB_MW=4; typedef icb_rsp_t {logic [31:0] rdata; logic err;}.
- Sub-module icb_rsp_fifo: a RSP_DEPTH × icb_rsp_t synchronous FIFO with push, pop, full, empty, count, and a head output. Read and write pointers wrap modulo RSP_DEPTH; count is one bit wider.
- Top level: decode, byte-lane write, array, error counter, and FIFO instance.

## Test plan
- Write 32'hDEAD_BEEF with wmask 4'hF to 32'h1000_0010, then read it → rsp err=0, rdata=32'hDEAD_BEEF; the first response (the write) has rdata=0.
- Write 32'h1122_3344 full to 32'h1000_0000, then write 32'hAABB_CCDD with wmask 4'b0101, then read → rdata=32'h11BB_33DD.
- Read 32'h1000_0400 (out of range, DEPTH=256) and write 32'h1000_0002 (misaligned) → both err=1, rdata=0; err_count=2; memory unchanged.
- Hold icb_rsp_ready=0 and issue 3 back-to-back reads → 2 accepted, icb_cmd_ready=0. Raise icb_rsp_ready → responses arrive in order, and the third command is accepted the cycle after the first pop.
- Stream 16 writes, then 16 reads, each one per cycle with icb_rsp_ready=1 → no stall cycles; all 16 reads return their written data.
- Assert rst for one cycle with 2 responses queued → next cycle icb_rsp_valid=0, icb_cmd_ready=1, err_count=0.
